// File: rtl/relu_activation_unit_if.sv
// Lane bundle between the requantizer and the activation stage.
// The master side drives the operands; the slave side returns registered results.
interface relu_activation_unit_if #(
    parameter int WIDTH = 8
);
    logic                    in_valid;
    logic [1:0]              mode;
    logic signed [WIDTH-1:0] q1;
    logic signed [WIDTH-1:0] q2;
    logic signed [WIDTH-1:0] q3;
    logic signed [WIDTH-1:0] q4;
    logic                    out_valid;
    logic signed [WIDTH-1:0] a1;
    logic signed [WIDTH-1:0] a2;
    logic signed [WIDTH-1:0] a3;
    logic signed [WIDTH-1:0] a4;

    modport master (
        output in_valid, mode, q1, q2, q3, q4,
        input  out_valid, a1, a2, a3, a4
    );

    modport slave (
        input  in_valid, mode, q1, q2, q3, q4,
        output out_valid, a1, a2, a3, a4
    );
endinterface

// File: rtl/relu_activation_unit.sv
// Four-lane int8 activation stage (ReLU / bypass / leaky ReLU), one-cycle registered latency.
// Results hold while in_valid is low; synchronous active-high reset clears everything.
module relu_activation_unit #(
    parameter int WIDTH = 8
) (
    input logic                   clk,
    input logic                   rst,
    relu_activation_unit_if.slave io
);
    localparam int LANES = 4;

    typedef enum logic [1:0] {
        MODE_RELU   = 2'b00,
        MODE_BYPASS = 2'b01,
        MODE_LEAKY  = 2'b10,
        MODE_RSVD   = 2'b11
    } act_mode_e;

    logic signed [WIDTH-1:0] q_lane [LANES];
    logic signed [WIDTH-1:0] a_d    [LANES];
    logic signed [WIDTH-1:0] a_q    [LANES];
    logic                    out_valid_d;
    logic                    out_valid_q;
    act_mode_e               mode_sel;

    assign q_lane[0] = io.q1;
    assign q_lane[1] = io.q2;
    assign q_lane[2] = io.q3;
    assign q_lane[3] = io.q4;
    assign mode_sel  = act_mode_e'(io.mode);

    // The reserved encoding falls through to ReLU; leaky uses an arithmetic
    // shift so negatives round toward minus infinity (-1 stays -1).
    function automatic logic signed [WIDTH-1:0] activate(
        input logic signed [WIDTH-1:0] x,
        input act_mode_e               m
    );
        logic signed [WIDTH-1:0] y;
        case (m)
            MODE_BYPASS: y = x;
            MODE_LEAKY:  y = x[WIDTH-1] ? (x >>> 3) : x;
            default:     y = x[WIDTH-1] ? '0 : x;
        endcase
        return y;
    endfunction

    always_comb begin
        // NOTE: every combinational output gets a default before any branch,
        // otherwise a missed path infers a latch.
        out_valid_d = io.in_valid;
        for (int i = 0; i < LANES; i++) begin
            a_d[i] = a_q[i];
            if (io.in_valid) begin
                a_d[i] = activate(q_lane[i], mode_sel);
            end
        end
    end

    always_ff @(posedge clk) begin
        // NOTE: state updates use non-blocking assignments so every register
        // samples the pre-edge value regardless of statement order.
        if (rst) begin
            out_valid_q <= 1'b0;
            for (int i = 0; i < LANES; i++) begin
                a_q[i] <= '0;
            end
        end else begin
            out_valid_q <= out_valid_d;
            for (int i = 0; i < LANES; i++) begin
                a_q[i] <= a_d[i];
            end
        end
    end

    assign io.out_valid = out_valid_q;
    assign io.a1        = a_q[0];
    assign io.a2        = a_q[1];
    assign io.a3        = a_q[2];
    assign io.a4        = a_q[3];
endmodule

// File: tb/tb_relu_activation_unit.sv
// Self-checking bench for relu_activation_unit: directed vectors plus randomized
// traffic compared against an integer-arithmetic reference model.
module tb_relu_activation_unit;
    localparam int WIDTH = 8;

    logic clk;
    logic rst;
    int   n_checks;
    int   n_fail;
    int   exp_a [4];
    int   exp_v;
    int   pulses;

    relu_activation_unit_if #(.WIDTH(WIDTH)) io ();

    relu_activation_unit #(.WIDTH(WIDTH)) dut (
        .clk (clk),
        .rst (rst),
        .io  (io.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input int got, input int exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
        end
    endtask

    // Reference activation with plain integer arithmetic; leaky is floor(x/8).
    function automatic int ref_act(input int x, input int m);
        if (m == 1) return x;
        if (x >= 0) return x;
        if (m == 2) return -((-x + 7) / 8);
        return 0;
    endfunction

    // Apply one cycle of stimulus, advance the model, compare after the edge.
    task automatic step(input bit r, input bit v, input int m,
                        input int x0, input int x1, input int x2, input int x3);
        int xs [4];
        xs[0] = x0; xs[1] = x1; xs[2] = x2; xs[3] = x3;
        rst         = r;
        io.in_valid = v;
        io.mode     = 2'(m);
        io.q1       = WIDTH'(x0);
        io.q2       = WIDTH'(x1);
        io.q3       = WIDTH'(x2);
        io.q4       = WIDTH'(x3);
        @(posedge clk);
        if (r) begin
            exp_v = 0;
            for (int i = 0; i < 4; i++) exp_a[i] = 0;
        end else if (v) begin
            exp_v = 1;
            for (int i = 0; i < 4; i++) exp_a[i] = ref_act(xs[i], m);
        end else begin
            exp_v = 0;
        end
        #1;
        check("model_out_valid", int'(io.out_valid), exp_v);
        check("model_a1", int'(io.a1), exp_a[0]);
        check("model_a2", int'(io.a2), exp_a[1]);
        check("model_a3", int'(io.a3), exp_a[2]);
        check("model_a4", int'(io.a4), exp_a[3]);
        if (io.out_valid === 1'b1) pulses++;
    endtask

    // Literal expectations taken directly from the worked examples.
    task automatic expect_lit(input string tag, input int v,
                              input int e0, input int e1, input int e2, input int e3);
        check({tag, "_valid"}, int'(io.out_valid), v);
        check({tag, "_a1"}, int'(io.a1), e0);
        check({tag, "_a2"}, int'(io.a2), e1);
        check({tag, "_a3"}, int'(io.a3), e2);
        check({tag, "_a4"}, int'(io.a4), e3);
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;
        pulses   = 0;
        exp_v    = 0;
        for (int i = 0; i < 4; i++) exp_a[i] = 0;

        // Reset with a simultaneous valid input: input must be dropped.
        step(1, 1, 0, 5, 5, 5, 5);
        step(1, 1, 0, 5, 5, 5, 5);
        expect_lit("reset_prio", 0, 0, 0, 0, 0);

        step(0, 1, 0, 10, 50, 127, 1);
        expect_lit("relu_pos", 1, 10, 50, 127, 1);
        step(0, 1, 0, -5, 0, -127, 100);
        expect_lit("relu_mixed", 1, 0, 0, 0, 100);
        step(0, 1, 0, -1, -20, -100, -128);
        expect_lit("relu_neg", 1, 0, 0, 0, 0);
        step(0, 1, 0, 0, 0, 0, 0);
        expect_lit("relu_zero", 1, 0, 0, 0, 0);

        step(0, 1, 1, -9, -1, -128, 7);
        expect_lit("bypass", 1, -9, -1, -128, 7);
        step(0, 1, 2, -9, -1, -128, 7);
        expect_lit("leaky", 1, -2, -1, -16, 7);
        step(0, 1, 2, -8, -7, -16, -17);
        expect_lit("leaky_edge", 1, -1, -1, -2, -3);
        step(0, 1, 3, -9, -1, -128, 7);
        expect_lit("mode11", 1, 0, 0, 0, 7);

        // Streaming: four back-to-back vectors, then a hold cycle.
        pulses = 0;
        step(0, 1, 0, 3, -3, 60, -60);
        step(0, 1, 2, -40, 40, -2, 2);
        step(0, 1, 1, -100, 99, 0, -1);
        step(0, 1, 1, 1, -2, 3, -4);
        check("stream_pulses", pulses, 4);
        expect_lit("stream_last", 1, 1, -2, 3, -4);
        step(0, 0, 0, -3, 3, -3, 3);
        expect_lit("hold", 0, 1, -2, 3, -4);

        // Reset while a result is presented, then idle: outputs stay cleared.
        step(0, 1, 1, 11, 22, 33, 44);
        expect_lit("pre_reset", 1, 11, 22, 33, 44);
        step(1, 1, 1, 55, 66, 77, 88);
        expect_lit("mid_reset", 0, 0, 0, 0, 0);
        step(0, 0, 1, 55, 66, 77, 88);
        expect_lit("post_reset_idle", 0, 0, 0, 0, 0);

        // Randomized traffic against the reference model.
        for (int n = 0; n < 1000; n++) begin
            step(($urandom_range(0, 49) == 0),
                 ($urandom_range(0, 3) != 0),
                 int'($urandom_range(0, 3)),
                 int'($urandom_range(0, 255)) - 128,
                 int'($urandom_range(0, 255)) - 128,
                 int'($urandom_range(0, 255)) - 128,
                 int'($urandom_range(0, 255)) - 128);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
